// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and the shift-count width helper
// for the ALU sequencing stage (alu_ctrl).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOTA = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_SHL1 = 3'd6,
        OP_SHR1 = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_ctrl_state_t;

    localparam int ALU_WIDTH_DEFAULT = 8;

    // Width of the shift-amount field; never below 1 so vectors stay legal.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Shift opcodes iterate; everything else is a single datapath pass.
    function automatic logic is_shift_op(input alu_op_t op);
        return (op == OP_SHL1) || (op == OP_SHR1);
    endfunction

endpackage

// File: rtl/alu_iter_counter.sv
// alu_iter_counter: loadable down-counter tracking the remaining
// single-bit iterations of the current ALU command.
module alu_iter_counter #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_last
);

    logic [CNT_W-1:0] r_count;

    // Load takes precedence over decrement; reset clears the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    // The iteration running while the count reads 1 is the final one.
    assign o_is_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer feeding the external result-mux bank.
// Accepts op/operands on a valid/ready port, iterates single-bit shifts,
// and returns the captured result on a valid/ready port.
// Optional feature macro: ALU_CTRL_FLAGS_EN builds registered zero/negative
// flags; when undefined, out_zero/out_neg are tied to 0.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [2:0]       mux_sel,
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg
);

    alu_ctrl_state_t  r_state;
    alu_ctrl_state_t  w_state_nxt;
    alu_op_t          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;

    logic             w_load;
    logic             w_dec;
    logic             w_is_last;
    logic             w_in_shift;
    logic             w_zero_shift;
    logic [CNT_W-1:0] w_load_val;
    logic             w_res_wr;
    logic [WIDTH-1:0] w_res_val;

    assign w_in_shift   = is_shift_op(alu_op_t'(in_op));
    assign w_load_val   = w_in_shift ? in_b[CNT_W-1:0] : CNT_W'(1);
    // Shift by zero skips the datapath entirely and returns operand A.
    assign w_zero_shift = w_in_shift && (in_b[CNT_W-1:0] == '0);

    // Result register is written either by a zero-count accept or by every EXEC cycle.
    assign w_res_wr  = (w_load && w_zero_shift) || w_dec;
    assign w_res_val = w_dec ? alu_result : in_a;

    alu_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_is_last  (w_is_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_zero_shift ? DONE : EXEC;
                end
            end
            EXEC: begin
                w_dec = 1'b1;
                if (w_is_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand staging and result capture; shifts feed the result back into mux_a.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_AND;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_load) begin
                r_op <= alu_op_t'(in_op);
                r_a  <= in_a;
                r_b  <= in_b;
            end else if (w_dec && is_shift_op(r_op)) begin
                r_a <= alu_result;
            end
            if (w_res_wr) begin
                r_result <= w_res_val;
            end
        end
    end

    assign mux_sel    = r_op;
    assign mux_a      = r_a;
    assign mux_b      = r_b;
    assign out_result = r_result;

`ifdef ALU_CTRL_FLAGS_EN
    logic r_zero;
    logic r_neg;

    // Flags track out_result, written on exactly the same cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_res_wr) begin
            r_zero <= (w_res_val == '0);
            r_neg  <= w_res_val[WIDTH-1];
        end
    end

    assign out_zero = r_zero;
    assign out_neg  = r_neg;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed cases plus randomized traffic for alu_ctrl,
// checked every cycle against a latency/result model of the command.
module tb_alu_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W);
`ifdef ALU_CTRL_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic [2:0]   mux_sel;
    logic [W-1:0] mux_a;
    logic [W-1:0] mux_b;
    logic [W-1:0] alu_result;
    logic         out_valid;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_neg;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .mux_sel    (mux_sel),
        .mux_a      (mux_a),
        .mux_b      (mux_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    // External result-mux bank: one pass of the selected operation.
    always_comb begin
        alu_result = '0;
        case (mux_sel)
            3'd0: alu_result = mux_a & mux_b;
            3'd1: alu_result = mux_a | mux_b;
            3'd2: alu_result = mux_a ^ mux_b;
            3'd3: alu_result = ~mux_a;
            3'd4: alu_result = mux_a + mux_b;
            3'd5: alu_result = mux_a - mux_b;
            3'd6: alu_result = {mux_a[W-2:0], 1'b0};
            default: alu_result = {1'b0, mux_a[W-1:1]};
        endcase
    end

    // Final answer of a whole command, shifts applied in one step.
    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int n;
        n = int'(b[CW-1:0]);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return a + b;
            3'd5: return a - b;
            3'd6: return a << n;
            default: return a >> n;
        endcase
    endfunction

    // Cycles from the accepting edge until out_valid is visible.
    function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
        int n;
        n = int'(b[CW-1:0]);
        if (op >= 3'd6) return n + 1;
        return 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every rising edge from the bench inputs only.
    int           cyc = 0;
    int           m_due = 0;
    bit           m_idle = 1'b1;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [2:0]   m_op = '0;
    logic [W-1:0] m_b = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_res   = '0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_idle  = 1'b1;
            end
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_op   = in_op;
                m_b    = in_b;
                m_res  = ref_res(in_op, in_a, in_b);
                if (ref_lat(in_op, in_b) == 1) m_valid = 1'b1;
                else m_due = cyc + ref_lat(in_op, in_b) - 1;
            end
        end else if (cyc == m_due) begin
            m_valid = 1'b1;
        end
        cyc++;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(m_idle));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_result", 32'(out_result), 32'(m_res));
                check("mux_sel", 32'(mux_sel), 32'(m_op));
                check("mux_b", 32'(mux_b), 32'(m_b));
                check("out_zero", 32'(out_zero), 32'(FLAGS_EN && (m_res == '0)));
                check("out_neg", 32'(out_neg), 32'(FLAGS_EN && m_res[W-1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_mux_sel", 32'(mux_sel), 32'd0);
        check("rst_mux_a", 32'(mux_a), 32'd0);
        check("rst_mux_b", 32'(mux_b), 32'd0);
        check("rst_flags", 32'({out_zero, out_neg}), 32'd0);

        // AND F0 & 3C = 30, valid in cycle 2.
        send(3'd0, 8'hF0, 8'h3C);
        check("and_c1_valid", 32'(out_valid), 32'd0);
        tick();
        check("and_c2_valid", 32'(out_valid), 32'd1);
        check("and_result", 32'(out_result), 32'h30);
        check("and_flags", 32'({out_zero, out_neg}), 32'd0);
        consume();
        check("and_idle_ready", 32'(in_ready), 32'd1);

        // SHL1 81 by 3: mux_a walks 81,02,04,08; valid in cycle 4.
        send(3'd6, 8'h81, 8'h03);
        check("shl_mux_a_c1", 32'(mux_a), 32'h81);
        tick();
        check("shl_mux_a_c2", 32'(mux_a), 32'h02);
        tick();
        check("shl_mux_a_c3", 32'(mux_a), 32'h04);
        check("shl_c3_valid", 32'(out_valid), 32'd0);
        tick();
        check("shl_mux_a_c4", 32'(mux_a), 32'h08);
        check("shl_c4_valid", 32'(out_valid), 32'd1);
        check("shl_result", 32'(out_result), 32'h08);
        consume();

        // SHR1 A5 with count field 0: passes A through in cycle 1.
        send(3'd7, 8'hA5, 8'h08);
        check("shr0_valid", 32'(out_valid), 32'd1);
        check("shr0_result", 32'(out_result), 32'hA5);
        check("shr0_neg", 32'(out_neg), 32'(FLAGS_EN));
        consume();

        // SUB 11-11 with back-pressure for 5 cycles.
        send(3'd5, 8'h11, 8'h11);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("sub_hold_valid", 32'(out_valid), 32'd1);
            check("sub_hold_result", 32'(out_result), 32'h00);
            check("sub_hold_zero", 32'(out_zero), 32'(FLAGS_EN));
            check("sub_hold_neg", 32'(out_neg), 32'd0);
            check("sub_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        check("sub_ready_at_pop", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check("sub_ready_after_pop", 32'(in_ready), 32'd1);

        // Reset in cycle 2 of SHL1 by 7 aborts the command.
        send(3'd6, 8'h13, 8'h07);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(out_result), 32'd0);
        check("abort_mux_a", 32'(mux_a), 32'd0);
        check("abort_mux_sel", 32'(mux_sel), 32'd0);
        send(3'd0, 8'h0F, 8'hFF);
        check("post_abort_accept", 32'(in_ready), 32'd0);
        tick();
        check("post_abort_result", 32'(out_result), 32'h0F);
        consume();

        // Randomized traffic with back-pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_op     = 3'($urandom);
            in_a      = W'($urandom);
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
